mux_sel_arbiter: RTL and testbench

//   Upstream stage of the 2:1 mux. Arbitrates two requesters (A, B), each with a

---
 rtl/mux_sel_arbiter_pkg.sv | 13 +
 rtl/mux_sel_arbiter.sv | 99 +++++++++
 tb/tb_mux_sel_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared encodings for the mux select arbiter and the downstream mux bench.
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for two requesters feeding a 2:1 mux.
// Captures the granted payload into a registered valid/ready output and
// returns to IDLE for one cycle after every transfer.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | no word held; sample requests, arbitrate on `last`
//   ST_GRANT_A | A's word held in out_data, waiting for out_ready
//   ST_GRANT_B | B's word held in out_data, waiting for out_ready
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  arb_state_t       state_q, state_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             xfer;

  assign xfer = valid_q & out_ready;

  // State and output registers; reset drops any held word without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_A;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= SEL_B;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the word while granted until it transfers.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        // A wins when alone, or when both ask and B was served last.
        if (req_a && (!req_b || last_q == SEL_B)) begin
          state_d = ST_GRANT_A;
          sel_d   = SEL_A;
          data_d  = data_a;
          valid_d = 1'b1;
          last_d  = SEL_A;
        end else if (req_b) begin
          state_d = ST_GRANT_B;
          sel_d   = SEL_B;
          data_d  = data_b;
          valid_d = 1'b1;
          last_d  = SEL_B;
        end
      end
      ST_GRANT_A, ST_GRANT_B: begin
        // sel is left alone so the mux keeps pointing at the last winner.
        if (xfer) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign ack_a     = xfer & (state_q == ST_GRANT_A);
  assign ack_b     = xfer & (state_q == ST_GRANT_B);
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed phases plus a scoreboard
// of expected grants that is drained whenever an ack pulse is observed.
module tb_mux_sel_arbiter;
  import mux_sel_arbiter_pkg::*;

  localparam int WIDTH = 1;

  typedef struct {
    logic             who;
    logic [WIDTH-1:0] data;
  } grant_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [WIDTH-1:0] data_a, data_b;
  logic             ack_a, ack_b;
  logic             sel, out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  grant_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     acks_seen = 0;
  bit     mon_en = 1'b0;

  mux_sel_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .ack_b     (ack_b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic who, input logic [WIDTH-1:0] d);
    grant_t g;
    g.who  = who;
    g.data = d;
    exp_q.push_back(g);
  endtask

  // Scoreboard: every ack must match the next expected grant.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ack_exclusive", int'(ack_a & ack_b), 0);
      if ((ack_a | ack_b) && !out_valid) chk("ack_without_valid", 1, 0);
      if (ack_a | ack_b) begin
        acks_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          grant_t g;
          g = exp_q.pop_front();
          chk("grant_who", int'(ack_b), int'(g.who));
          chk("grant_sel", int'(sel), int'(g.who));
          chk("grant_data", int'(out_data), int'(g.data));
          chk("mux_f", int'(sel ? data_b : data_a), int'(g.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    data_a = 1'b1; data_b = 1'b0; out_ready = 1'b1;

    // 1. Reset held with both requests high.
    for (int i = 0; i < 2; i++) begin
      tick();
      mon_en = 1'b1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_sel", int'(sel), 0);
      chk("rst_acks", int'(ack_a | ack_b), 0);
    end

    // 3. Contention from reset: A,B,A,B with one idle cycle between grants.
    push(SEL_A, 1'b1); push(SEL_B, 1'b0); push(SEL_A, 1'b1); push(SEL_B, 1'b0);
    rst = 1'b0;
    tick();
    chk("cont_first_valid", int'(out_valid), 1);
    chk("cont_first_ack_a", int'(ack_a), 1);
    tick();
    chk("cont_bubble", int'(out_valid), 0);
    for (int i = 0; i < 5; i++) tick();
    req_a = 1'b0; req_b = 1'b0;
    tick();
    chk("cont_acks", acks_seen, 4);
    chk("cont_drained", exp_q.size(), 0);

    // 2. Single A request, one-cycle latency.
    data_a = 1'b1; req_a = 1'b1;
    push(SEL_A, 1'b1);
    tick();
    chk("single_valid", int'(out_valid), 1);
    chk("single_sel", int'(sel), 0);
    chk("single_data", int'(out_data), 1);
    chk("single_ack_a", int'(ack_a), 1);
    req_a = 1'b0;
    tick();
    chk("single_idle", int'(out_valid), 0);

    // 4. Backpressure on a B grant.
    out_ready = 1'b0; data_b = 1'b1; req_b = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_sel", int'(sel), 1);
      chk("bp_data", int'(out_data), 1);
      chk("bp_no_ack", int'(ack_b), 0);
      tick();
    end
    push(SEL_B, 1'b1);
    out_ready = 1'b1;
    #1;
    chk("bp_ack_b", int'(ack_b), 1);
    req_b = 1'b0;
    tick();
    chk("bp_single_pulse", int'(ack_b), 0);
    chk("bp_idle", int'(out_valid), 0);

    // 5. Reset mid-grant drops the word and restores A priority.
    out_ready = 1'b0; req_a = 1'b1; data_a = 1'b0;
    tick();
    chk("mid_granted", int'(out_valid), 1);
    rst = 1'b1; req_a = 1'b0;
    tick();
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_no_ack", int'(ack_a), 0);
    rst = 1'b0;

    // 6. Both requesting after reset: A (0) then B (1) through the mux.
    data_a = 1'b0; data_b = 1'b1; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    push(SEL_A, 1'b0); push(SEL_B, 1'b1);
    tick();
    chk("post_rst_sel", int'(sel), 0);
    tick();
    tick();
    chk("post_rst_sel_b", int'(sel), 1);
    req_a = 1'b0; req_b = 1'b0;
    tick();
    tick();
    chk("final_drained", exp_q.size(), 0);
    chk("final_acks", acks_seen, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
